// File: rtl/ksm_wb_arb_if.sv
// ksm_wb_arb_if -- bundle of the arbiter's Wishbone signals.
//   m_*  : both master ports, lanes packed side by side (bit/field k = master k)
//   s_*  : the single shared slave port
//   gnt_o: registered one-hot grant
// Modports:
//   slave  - the arbiter's view (it is the slave of both masters)
//   master - the environment's view (masters + the shared slave)
interface ksm_wb_arb_if #(
  parameter int AW = 16
);
  // master side
  logic [1:0]      m_cyc_i;
  logic [1:0]      m_stb_i;
  logic [1:0]      m_we_i;
  logic [3:0]      m_sel_i;
  logic [2*AW-1:0] m_adr_i;
  logic [31:0]     m_dat_i;
  logic [15:0]     m_dat_o;
  logic [1:0]      m_ack_o;
  logic [1:0]      m_err_o;
  logic [1:0]      gnt_o;
  // slave side
  logic            s_cyc_o;
  logic            s_stb_o;
  logic            s_we_o;
  logic [1:0]      s_sel_o;
  logic [AW-1:0]   s_adr_o;
  logic [15:0]     s_dat_o;
  logic [15:0]     s_dat_i;
  logic            s_ack_i;

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
    output m_dat_o, m_ack_o, m_err_o, gnt_o,
    output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
    input  s_dat_i, s_ack_i
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
    input  m_dat_o, m_ack_o, m_err_o, gnt_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
    output s_dat_i, s_ack_i
  );
endinterface

// File: rtl/ksm_wb_arb.sv
// ksm_wb_arb -- two-master Wishbone arbiter with bus timeout.
// Master 0 is the VM2 CPU, master 1 the KGD/DMA agent; both share the
// terminal's slave bus.
// Ports:
//   wb_clk_i   - clock, all state changes on the rising edge
//   wb_rst_n_i - asynchronous active-low reset
//   bus        - ksm_wb_arb_if.slave: master ports, slave port, gnt_o
// Behaviour:
//   - grant is held for as long as the owner keeps cyc high (RMW bus lock)
//   - ties in IDLE go to the master that was not served last
//   - a strobe unanswered for TIMEOUT cycles is terminated with ack+err,
//     the slave strobe is withdrawn and read data is zeroed in that cycle
module ksm_wb_arb #(
  parameter int TIMEOUT = 64,
  parameter int AW      = 16
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_n_i,
  ksm_wb_arb_if.slave  bus
);

  localparam int NUM_M = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t           state;
  logic [NUM_M-1:0] gnt;     // registered one-hot, mirrors state
  logic             lp;      // last-served master
  logic [7:0]       cnt;     // cycles the current strobe has waited
  logic             rst_q;   // low for the first edge after reset release

  logic             own_cyc;
  logic             own_stb;
  logic             own_we;
  logic [1:0]       own_sel;
  logic [AW-1:0]    own_adr;
  logic [15:0]      own_dat;
  logic             stb_raw;
  logic             tmo;

  // Owner mux: AND-OR across lanes, all-zero when nobody holds the grant.
  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_we  = 1'b0;
    own_sel = '0;
    own_adr = '0;
    own_dat = '0;
    for (int k = 0; k < NUM_M; k++) begin
      if (gnt[k]) begin
        own_cyc = bus.m_cyc_i[k];
        own_stb = bus.m_stb_i[k];
        own_we  = bus.m_we_i[k];
        own_sel = bus.m_sel_i[2*k +: 2];
        own_adr = bus.m_adr_i[AW*k +: AW];
        own_dat = bus.m_dat_i[16*k +: 16];
      end
    end
  end

  // A strobe only counts while the owner's cycle is still open; dropping
  // cyc abandons the transfer.
  assign stb_raw = own_cyc & own_stb;
  assign tmo     = (cnt == 8'(TIMEOUT)) & stb_raw & ~bus.s_ack_i;

  assign bus.s_cyc_o = own_cyc;
  assign bus.s_stb_o = stb_raw & ~tmo;
  assign bus.s_we_o  = own_we;
  assign bus.s_sel_o = own_sel;
  assign bus.s_adr_o = own_adr;
  assign bus.s_dat_o = own_dat;

  // gnt gating makes s_ack_i irrelevant in IDLE and keeps the
  // non-owner's ack/err at zero.
  genvar gk;
  generate
    for (gk = 0; gk < NUM_M; gk++) begin : g_lane
      assign bus.m_ack_o[gk] = gnt[gk] & (bus.s_ack_i | tmo);
      assign bus.m_err_o[gk] = gnt[gk] & tmo;
    end
  endgenerate

  assign bus.m_dat_o = tmo ? 16'h0000 : bus.s_dat_i;
  assign bus.gnt_o   = gnt;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state <= IDLE;
      gnt   <= '0;
      lp    <= 1'b1;           // master 0 wins the first tie
      cnt   <= '0;
      rst_q <= 1'b0;
    end else begin
      rst_q <= 1'b1;

      // An ownership change always coincides with stb_raw=0 (owner cyc low
      // or IDLE), so this single rule also clears cnt on handover. cnt can
      // never pass TIMEOUT: at TIMEOUT it is cleared by ack, tmo or !stb.
      if (!stb_raw || bus.s_ack_i || tmo) cnt <= '0;
      else                                cnt <= cnt + 8'd1;

      case (state)
        IDLE: begin
          // rst_q holds off arbitration on the first edge after release
          if (rst_q) begin
            if (bus.m_cyc_i[0] && (!bus.m_cyc_i[1] || lp)) begin
              state <= OWN0;
              gnt   <= 2'b01;
            end else if (bus.m_cyc_i[1]) begin
              state <= OWN1;
              gnt   <= 2'b10;
            end
          end
        end
        OWN0: begin
          if (!bus.m_cyc_i[0]) begin
            lp <= 1'b0;
            if (bus.m_cyc_i[1]) begin
              state <= OWN1;
              gnt   <= 2'b10;
            end else begin
              state <= IDLE;
              gnt   <= 2'b00;
            end
          end
        end
        OWN1: begin
          if (!bus.m_cyc_i[1]) begin
            lp <= 1'b1;
            if (bus.m_cyc_i[0]) begin
              state <= OWN0;
              gnt   <= 2'b01;
            end else begin
              state <= IDLE;
              gnt   <= 2'b00;
            end
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ksm_wb_arb.sv
// tb_ksm_wb_arb -- directed bench for ksm_wb_arb. Stimulus pushes the
// expected master response into exp_q; a monitor on the falling edge pops
// and compares whenever the arbiter raises any ack/err.
module tb_ksm_wb_arb;
  localparam int AW = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ksm_wb_arb_if #(.AW(AW)) bus ();

  ksm_wb_arb #(.TIMEOUT(64), .AW(AW)) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .bus        (bus)
  );

  typedef struct {
    logic [1:0]  ack;
    logic [1:0]  err;
    logic [15:0] dat;
    string       name;
  } resp_t;

  resp_t exp_q[$];
  int    n_chk = 0;
  int    n_err = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic push(input string name, input logic [1:0] ack, input logic [1:0] err,
                      input logic [15:0] dat);
    resp_t e;
    e.name = name; e.ack = ack; e.err = err; e.dat = dat;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    resp_t e;
    if (bus.m_ack_o !== 2'b00 || bus.m_err_o !== 2'b00) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_resp: ack=%b err=%b with nothing expected at %0t",
                 bus.m_ack_o, bus.m_err_o, $time);
      end else begin
        e = exp_q.pop_front();
        chk({e.name, "_ack"}, 32'(bus.m_ack_o), 32'(e.ack));
        chk({e.name, "_err"}, 32'(bus.m_err_o), 32'(e.err));
        chk({e.name, "_dat"}, 32'(bus.m_dat_o), 32'(e.dat));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  // Waits in cycle 0 with a strobe, then either times out or gets acked in cycle 64.
  task automatic run_tmo(input bit ack_at_end, input string name);
    bus.m_cyc_i = 2'b01; bus.m_stb_i = 2'b01; bus.m_we_i = 2'b00;
    bus.s_ack_i = 1'b0;  bus.s_dat_i = 16'hABCD;
    step();
    smp(); chk({name, "_stb_c0"}, 32'(bus.s_stb_o), 32'd1);
    for (int j = 1; j <= 64; j++) begin
      step();
      if (j == 63) begin
        smp(); chk({name, "_stb_c63"}, 32'(bus.s_stb_o), 32'd1);
      end
    end
    if (ack_at_end) begin
      bus.s_ack_i = 1'b1; bus.s_dat_i = 16'h5A5A;
      push(name, 2'b01, 2'b00, 16'h5A5A);
    end else begin
      push(name, 2'b01, 2'b01, 16'h0000);
    end
    smp();
    chk({name, "_stb_c64"}, 32'(bus.s_stb_o), ack_at_end ? 32'd1 : 32'd0);
    chk({name, "_mdat_c64"}, 32'(bus.m_dat_o), ack_at_end ? 32'h5A5A : 32'h0);
    step();
    bus.s_ack_i = 1'b0; bus.m_cyc_i = 2'b00; bus.m_stb_i = 2'b00;
    smp(); chk({name, "_ack_post"}, 32'(bus.m_ack_o), 32'd0);
    step();
    smp(); chk({name, "_idle"}, 32'(bus.gnt_o), 32'd0);
  endtask

  initial begin
    int          k;
    logic [1:0]  oh;

    bus.m_cyc_i = 2'b01; bus.m_stb_i = 2'b01; bus.m_we_i = 2'b00;
    bus.m_sel_i = 4'b0011;
    bus.m_adr_i = {16'h0000, 16'o170000};
    bus.m_dat_i = 32'h0;
    bus.s_dat_i = 16'h0; bus.s_ack_i = 1'b0;

    // reset state, with master 0 already requesting
    #2;
    chk("rst_gnt",  32'(bus.gnt_o),   32'd0);
    chk("rst_scyc", 32'(bus.s_cyc_o), 32'd0);
    chk("rst_sadr", 32'(bus.s_adr_o), 32'd0);
    chk("rst_ack",  32'(bus.m_ack_o), 32'd0);

    // release mid-cycle; no grant on the first edge, grant on the second
    smp(); rst_n = 1'b1;
    step(); smp(); chk("rel_edge1_gnt", 32'(bus.gnt_o), 32'd0);
    step(); smp();
    chk("single_gnt",  32'(bus.gnt_o),   32'h1);
    chk("single_scyc", 32'(bus.s_cyc_o), 32'd1);
    chk("single_sstb", 32'(bus.s_stb_o), 32'd1);
    chk("single_sadr", 32'(bus.s_adr_o), 32'hF000);
    chk("single_ssel", 32'(bus.s_sel_o), 32'h3);
    step();                                    // stb cycle 1
    step();                                    // stb cycle 2: slave acks
    bus.s_ack_i = 1'b1; bus.s_dat_i = 16'h1234;
    push("single", 2'b01, 2'b00, 16'h1234);
    smp();
    step();
    bus.s_ack_i = 1'b0; bus.m_cyc_i = 2'b00; bus.m_stb_i = 2'b00;
    smp(); chk("single_ack_once", 32'(bus.m_ack_o), 32'd0);
    step(); smp();
    chk("single_idle_gnt",  32'(bus.gnt_o),   32'd0);
    chk("single_idle_sadr", 32'(bus.s_adr_o), 32'd0);
    chk("single_idle_ssel", 32'(bus.s_sel_o), 32'd0);

    // tie fairness after a fresh reset: 01,10,01,10
    #1; rst_n = 1'b0;
    bus.m_cyc_i = 2'b11; bus.m_stb_i = 2'b11;
    bus.m_adr_i = {16'h2222, 16'h1111};
    #1; rst_n = 1'b1;
    step(); smp(); chk("fair_edge1_gnt", 32'(bus.gnt_o), 32'd0);
    step();
    for (int i = 0; i < 4; i++) begin
      k  = i % 2;
      oh = (k == 0) ? 2'b01 : 2'b10;
      bus.s_ack_i = 1'b1; bus.s_dat_i = 16'hA000 + 16'(i);
      push("fair", oh, 2'b00, 16'hA000 + 16'(i));
      smp();
      chk("fair_gnt",  32'(bus.gnt_o),   32'(oh));
      chk("fair_sadr", 32'(bus.s_adr_o), (k == 0) ? 32'h1111 : 32'h2222);
      step();
      bus.s_ack_i = 1'b0; bus.m_cyc_i[k] = 1'b0; bus.m_stb_i[k] = 1'b0;
      if (i == 3) begin bus.m_cyc_i = 2'b00; bus.m_stb_i = 2'b00; end
      smp(); chk("fair_hold", 32'(bus.gnt_o), 32'(oh));
      step();
      if (i != 3) begin bus.m_cyc_i[k] = 1'b1; bus.m_stb_i[k] = 1'b1; end
    end
    smp(); chk("fair_idle", 32'(bus.gnt_o), 32'd0);

    // lock: m0 holds cyc over two strobes while m1 waits
    step();
    bus.m_cyc_i = 2'b01; bus.m_stb_i = 2'b01; bus.m_we_i = 2'b00;
    bus.m_adr_i = {16'h3333, 16'o001000};
    smp(); chk("lock_pre_gnt", 32'(bus.gnt_o), 32'd0);
    step();
    bus.m_cyc_i = 2'b11; bus.m_stb_i = 2'b11;
    bus.s_ack_i = 1'b1; bus.s_dat_i = 16'h0BAD;
    push("rmw_rd", 2'b01, 2'b00, 16'h0BAD);
    smp(); chk("lat1_gnt", 32'(bus.gnt_o), 32'h1);
    step();
    bus.s_ack_i = 1'b0; bus.m_stb_i[0] = 1'b0;
    smp();
    chk("lock_gap_gnt",  32'(bus.gnt_o),   32'h1);
    chk("lock_gap_sstb", 32'(bus.s_stb_o), 32'd0);
    step();
    bus.m_stb_i[0] = 1'b1; bus.m_we_i[0] = 1'b1; bus.m_dat_i = {16'h0000, 16'hBEEF};
    bus.s_ack_i = 1'b1; bus.s_dat_i = 16'h0000;
    push("rmw_wr", 2'b01, 2'b00, 16'h0000);
    smp();
    chk("rmw_wr_swe",  32'(bus.s_we_o),  32'd1);
    chk("rmw_wr_sdat", 32'(bus.s_dat_o), 32'hBEEF);
    chk("rmw_wr_gnt",  32'(bus.gnt_o),   32'h1);
    step();
    bus.s_ack_i = 1'b0; bus.m_cyc_i[0] = 1'b0; bus.m_stb_i[0] = 1'b0; bus.m_we_i = 2'b00;
    smp(); chk("lock_drop_gnt", 32'(bus.gnt_o), 32'h1);
    step();
    bus.s_ack_i = 1'b1; bus.s_dat_i = 16'h7777;
    push("m1_after_lock", 2'b10, 2'b00, 16'h7777);
    smp();
    chk("lock_handover_gnt",  32'(bus.gnt_o),   32'h2);
    chk("lock_handover_sadr", 32'(bus.s_adr_o), 32'h3333);
    step();
    bus.s_ack_i = 1'b0; bus.m_cyc_i = 2'b00; bus.m_stb_i = 2'b00;
    step(); smp(); chk("lock_idle", 32'(bus.gnt_o), 32'd0);

    // timeout, then ack coinciding with the boundary
    step();
    run_tmo(1'b0, "tmo");
    step();
    run_tmo(1'b1, "coinc");

    // async reset in the middle of a master 1 write
    step();
    bus.m_cyc_i = 2'b10; bus.m_stb_i = 2'b10; bus.m_we_i = 2'b10;
    bus.m_sel_i = 4'b1000;
    bus.m_adr_i = {16'h4444, 16'h0000};
    bus.m_dat_i = {16'hC0DE, 16'h0000};
    step(); smp();
    chk("m1_gnt",  32'(bus.gnt_o),   32'h2);
    chk("m1_swe",  32'(bus.s_we_o),  32'd1);
    chk("m1_sdat", 32'(bus.s_dat_o), 32'hC0DE);
    chk("m1_ssel", 32'(bus.s_sel_o), 32'h2);
    chk("m1_sadr", 32'(bus.s_adr_o), 32'h4444);
    #2; rst_n = 1'b0;
    #1; bus.s_ack_i = 1'b1;
    #1;
    chk("arst_gnt",  32'(bus.gnt_o),   32'd0);
    chk("arst_scyc", 32'(bus.s_cyc_o), 32'd0);
    chk("arst_sstb", 32'(bus.s_stb_o), 32'd0);
    chk("arst_swe",  32'(bus.s_we_o),  32'd0);
    chk("arst_sadr", 32'(bus.s_adr_o), 32'd0);
    chk("arst_sdat", 32'(bus.s_dat_o), 32'd0);
    chk("arst_ssel", 32'(bus.s_sel_o), 32'd0);
    chk("arst_ack",  32'(bus.m_ack_o), 32'd0);
    chk("arst_err",  32'(bus.m_err_o), 32'd0);
    step(); step();
    bus.s_ack_i = 1'b0; bus.m_cyc_i = 2'b00; bus.m_stb_i = 2'b00; bus.m_we_i = 2'b00;
    rst_n = 1'b1;
    step(); step(); smp();
    chk("pending_resp", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ksm_wb_arb.md
KSM_WB_ARB -- requirements
Module: ksm_wb_arb

Purpose: two-master Wishbone arbiter with bus timeout. Shares the terminal's slave bus between master 0 (VM2 CPU) and master 1 (KGD/DMA agent).

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64 (legal 2..255): cycles an owner strobe may wait for s_ack_i before a forced error termination.
REQ-002 SHALL have parameter AW, default 16: address width.
REQ-003 SHALL have port wb_clk_i  in  1  clock; all state changes on rising edge.
REQ-004 SHALL have port wb_rst_n_i  in  1  reset; asynchronous, active-low.
REQ-005 SHALL have port m_cyc_i  in  2  per-master cycle request; bit k = master k.
REQ-006 SHALL have port m_stb_i  in  2  per-master strobe.
REQ-007 SHALL have port m_we_i  in  2  per-master write enable.
REQ-008 SHALL have port m_sel_i  in  4  byte selects; [2k+1:2k] = master k.
REQ-009 SHALL have port m_adr_i  in  2*AW  addresses; [AW*(k+1)-1:AW*k] = master k.
REQ-010 SHALL have port m_dat_i  in  32  write data; [16k+15:16k] = master k.
REQ-011 SHALL have port m_dat_o  out  16  read data, shared by both masters.
REQ-012 SHALL have port m_ack_o  out  2  per-master acknowledge.
REQ-013 SHALL have port m_err_o  out  2  per-master timeout error; 1-cycle pulse.
REQ-014 SHALL have port gnt_o  out  2  registered one-hot grant; 00 = idle.
REQ-015 SHALL have ports s_cyc_o, s_stb_o, s_we_o  out  1 each  slave control.
REQ-016 SHALL have ports s_sel_o  out  2; s_adr_o  out  AW; s_dat_o  out  16  slave selects, address and write data.
REQ-017 SHALL have ports s_dat_i  in  16; s_ack_i  in  1  slave read data and acknowledge.

Function
REQ-018 SHALL implement an FSM with states IDLE, OWN0 and OWN1; gnt_o = {OWN1, OWN0}.
REQ-019 IDLE transitions:
- only master k has m_cyc_i[k]=1 -> OWNk at the next edge (1-cycle arbitration latency).
- both request -> grant the master other than the last-served pointer lp.
REQ-020 OWNk SHALL persist while m_cyc_i[k]=1, irrespective of stb; this holds the bus lock for VM2 read-modify-write.
REQ-021 OWNk with m_cyc_i[k]=0: set lp<=k, then move to OWN(1-k) if m_cyc_i[1-k]=1, else to IDLE.
REQ-022 Slave outputs SHALL be combinationally muxed from the owner. In IDLE, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o and s_dat_o SHALL all be 0.
REQ-023 m_ack_o[k] SHALL equal gnt_o[k] & (s_ack_i | tmo); the non-owner's ack and err SHALL always be 0.
REQ-024 s_ack_i in IDLE SHALL be ignored.
REQ-025 Timeout counter cnt, 8 bits:
- increments on each edge where s_stb_o=1 and s_ack_i=0.
- clears when s_stb_o=0, on s_ack_i=1, or on an ownership change.
REQ-026 tmo = (cnt==TIMEOUT) & s_stb_o_raw & ~s_ack_i. While tmo=1:
- s_stb_o is forced to 0.
- m_ack_o[k] and m_err_o[k] are 1 for owner k.
- m_dat_o = 0.
- cnt clears at the next edge.
REQ-027 When s_ack_i and the TIMEOUT boundary coincide, s_ack_i SHALL win: normal ack, no err, data passed.
REQ-028 m_dat_o SHALL equal s_dat_i whenever tmo=0.
REQ-029 If the owner drops cyc with a strobe pending, the transfer SHALL be abandoned with no ack and cnt cleared.
REQ-030 The counter SHALL NOT saturate or wrap past TIMEOUT.

Reset
REQ-031 wb_rst_n_i=0 SHALL immediately force: state IDLE, gnt_o=00, cnt=0, lp=1 (master 0 wins the first tie), m_ack_o=00, m_err_o=00, and all slave outputs 0. This applies mid-transaction, with no completion of the abandoned cycle.
REQ-032 After release, the first grant SHALL occur no earlier than the second rising edge after deassertion.

Verification
REQ-033 Single master: m_cyc_i=01, m_stb_i=01, adr 0o170000, slave acks 2 cycles after stb -> gnt_o=01 one edge after request; m_ack_o=01 for one cycle; m_dat_o = s_dat_i.
REQ-034 Tie fairness: both request continuously, each master drops cyc after one acked access -> grant order 01,10,01,10; first grant to master 0 after reset.
REQ-035 Lock: master 0 holds cyc across 2 strobes (RMW) while master 1 requests -> gnt_o stays 01 until m0 cyc falls, then 10 at the next edge.
REQ-036 Timeout: TIMEOUT=64, slave never acks -> m_ack_o and m_err_o = 01 in cycle 64 after the first stb cycle; s_stb_o=0 in that cycle; m_dat_o=0.
REQ-037 Coincidence: s_ack_i asserted exactly in cycle 64 -> m_ack_o=01, m_err_o=00.
REQ-038 Async reset pulse in the middle of a master 1 transfer -> gnt_o=00 and slave outputs 0 without a clock edge; no ack is issued.
